// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit width and the add-3 adjust constants.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned BCD_W      = 4;
  localparam logic [3:0]  ADJ_THRESH = 4'd5;
  localparam logic [3:0]  ADJ_OFFSET = 4'd3;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit corrector: adds 3 to a BCD digit that is 5 or more
// so the following left shift carries correctly into the next digit.
//   digit_in   in   4   working digit before the shift
//   digit_out  out  4   corrected digit (0 for the unreachable inputs 13..15)
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] digit_in,
  output logic [BCD_W-1:0] digit_out
);

  always_comb begin
    digit_out = '0;
    if (digit_in < ADJ_THRESH) begin
      digit_out = digit_in;
    end else if (digit_in <= 4'd12) begin
      digit_out = digit_in + ADJ_OFFSET;
    end
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
//   clk       in   1          rising-edge clock
//   reset     in   1          synchronous active-high reset
//   start     in   1          conversion request, honoured when not busy
//   bin       in   WIDTH      unsigned operand, captured on the accepting edge
//   busy      out  1          conversion in progress
//   done      out  1          one-cycle pulse, bcd/overflow just updated
//   bcd       out  4*DIGITS   packed BCD result, units digit in [3:0]
//   overflow  out  1          value did not fit in DIGITS digits
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int unsigned CNT_W  = $clog2(WIDTH + 1);
  localparam int unsigned WORK_W = BCD_W * DIGITS;

  state_t             state, state_next;
  logic [CNT_W-1:0]   counter;
  logic [WIDTH-1:0]   bin_reg;
  logic [WORK_W-1:0]  work, work_adj, work_next;
  logic [WORK_W-1:0]  bcd_q;
  logic               ovf_sticky, ovf_next, ovf_q;
  logic               accept, last_iter;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (work[g*BCD_W +: BCD_W]),
      .digit_out (work_adj[g*BCD_W +: BCD_W])
    );
  end

  always_comb begin
    accept    = start && (state != ST_CONV);
    last_iter = (state == ST_CONV) && (counter == CNT_W'(WIDTH - 1));
    // Shift the adjusted digits left; binary MSB enters the units digit,
    // the top digit's MSB falls out into the sticky overflow.
    work_next = {work_adj[WORK_W-2:0], bin_reg[WIDTH-1]};
    ovf_next  = ovf_sticky | work_adj[WORK_W-1];

    state_next = state;
    case (state)
      ST_IDLE: if (start)     state_next = ST_CONV;
      ST_CONV: if (last_iter) state_next = ST_DONE;
      ST_DONE: state_next = start ? ST_CONV : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter    <= '0;
      bin_reg    <= '0;
      work       <= '0;
      ovf_sticky <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else if (accept) begin
      counter    <= '0;
      bin_reg    <= bin;
      work       <= '0;
      ovf_sticky <= 1'b0;
    end else if (state == ST_CONV) begin
      counter    <= counter + CNT_W'(1);
      bin_reg    <= bin_reg << 1;
      work       <= work_next;
      ovf_sticky <= ovf_next;
      if (last_iter) begin
        bcd_q <= work_next;
        ovf_q <= ovf_next;
      end
    end
  end

  assign busy     = (state == ST_CONV);
  assign done     = (state == ST_DONE);
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start3 = 1'b0, start2 = 1'b0;
  logic [7:0]  bin3 = '0, bin2 = '0;
  logic        busy3, done3, ovf3, busy2, done2, ovf2;
  logic [11:0] bcd3;
  logic [7:0]  bcd2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [11:0] bcd;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t q3[$];
  exp_t q2[$];
  exp_t e3, e2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .bin(bin3),
    .busy(busy3), .done(done3), .bcd(bcd3), .overflow(ovf3)
  );

  bin2bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(ovf2)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [12:0] model(input int v, input int nd);
    logic [11:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return {(t != 0), r};
  endfunction

  // Expected results are queued on the accepting edge and consumed on done.
  always @(negedge clk) begin
    if (!reset) begin
      if (done3) begin
        if (q3.size() == 0) check_val("d3_spurious_done", 32'(done3), 32'd0);
        else begin
          e3 = q3.pop_front();
          check_val("d3_bcd", 32'(bcd3), 32'(e3.bcd));
          check_val("d3_ovf", 32'(ovf3), 32'(e3.ovf));
          check_val("d3_latency", 32'(cyc), 32'(e3.cyc));
        end
      end else if (q3.size() > 0 && cyc > q3[0].cyc) begin
        check_val("d3_missing_done", 32'(done3), 32'd1);
        void'(q3.pop_front());
      end
      if (done2) begin
        if (q2.size() == 0) check_val("d2_spurious_done", 32'(done2), 32'd0);
        else begin
          e2 = q2.pop_front();
          check_val("d2_bcd", 32'(bcd2), 32'(e2.bcd[7:0]));
          check_val("d2_ovf", 32'(ovf2), 32'(e2.ovf));
          check_val("d2_latency", 32'(cyc), 32'(e2.cyc));
        end
      end else if (q2.size() > 0 && cyc > q2[0].cyc) begin
        check_val("d2_missing_done", 32'(done2), 32'd1);
        void'(q2.pop_front());
      end
    end
  end

  task automatic push3(input int v, input int due);
    exp_t e;
    logic [12:0] m;
    m = model(v, 3);
    e.bcd = m[11:0];
    e.ovf = m[12];
    e.cyc = due;
    q3.push_back(e);
  endtask

  task automatic push2(input int v, input int due);
    exp_t e;
    logic [12:0] m;
    m = model(v, 2);
    e.bcd = m[11:0];
    e.ovf = m[12];
    e.cyc = due;
    q2.push_back(e);
  endtask

  // Returns #1 after the accepting edge; bin is scrambled while busy.
  task automatic launch3(input int v);
    @(negedge clk);
    start3 = 1'b1;
    bin3   = 8'(v);
    @(posedge clk);
    #1;
    start3 = 1'b0;
    bin3   = 8'($urandom);
    push3(v, cyc + 8);
  endtask

  task automatic launch2(input int v);
    @(negedge clk);
    start2 = 1'b1;
    bin2   = 8'(v);
    @(posedge clk);
    #1;
    start2 = 1'b0;
    bin2   = 8'($urandom);
    push2(v, cyc + 8);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (q3.size() == 0 && q2.size() == 0) break;
      @(negedge clk);
    end
    check_val(tag, 32'(q3.size() + q2.size()), 32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_val("rst_busy", 32'(busy3), 32'd0);
    check_val("rst_done", 32'(done3), 32'd0);
    check_val("rst_bcd", 32'(bcd3), 32'd0);
    check_val("rst_ovf", 32'(ovf3), 32'd0);
    reset = 1'b0;

    // 255: busy exactly 8 cycles, then done
    launch3(255);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check_val("t1_busy", 32'(busy3), 32'd1);
    end
    @(negedge clk);
    check_val("t1_busy_end", 32'(busy3), 32'd0);
    drain("t1_drain");
    repeat (3) @(negedge clk);
    check_val("t1_hold", 32'(bcd3), 32'h255);

    // fixed and random values, both widths
    launch3(0);   drain("t2_0");
    launch3(99);  drain("t2_99");
    launch3(128); drain("t2_128");
    for (int k = 0; k < 4; k++) begin
      launch3(int'($urandom_range(0, 255)));
      drain("t2_rand");
    end
    launch2(100); drain("t3_100");
    launch2(99);  drain("t3_99");
    launch2(255); drain("t3_255");
    launch2(int'($urandom_range(0, 255))); drain("t3_rand");

    // start held high: second operand accepted in the DONE cycle
    @(negedge clk);
    start3 = 1'b1;
    bin3   = 8'd37;
    @(posedge clk);
    #1;
    n = cyc;
    push3(37, n + 8);
    push3(200, n + 17);
    repeat (9) @(negedge clk);
    bin3 = 8'd200;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    drain("t4_drain");

    // start during CONV cycle 3 is ignored
    launch3(55);
    repeat (3) @(negedge clk);
    start3 = 1'b1;
    bin3   = 8'd99;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    drain("t5_drain");
    repeat (12) @(negedge clk);
    check_val("t5_result", 32'(bcd3), 32'h055);

    // reset during CONV cycle 4 aborts
    launch3(201);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q3.delete();
    @(negedge clk);
    check_val("t6_busy", 32'(busy3), 32'd0);
    check_val("t6_done", 32'(done3), 32'd0);
    check_val("t6_bcd", 32'(bcd3), 32'd0);
    check_val("t6_ovf", 32'(ovf3), 32'd0);
    repeat (10) @(negedge clk);
    launch3(201);
    drain("t6_fresh");

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
